embedding_fetch: RTL and testbench

EMBEDDING_FETCH -- requirements
Module: embedding_fetch

---
 rtl/embedding_fetch.sv | 127 ++++++++++++
 tb/tb_embedding_fetch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/embedding_fetch.sv
// embedding_fetch: turns a stream of token indices into a stream of embedding
// vectors read from an external single-cycle-latency table. Each sequence is
// SEQ_LEN tokens long. A 3-entry FIFO absorbs returning reads. A credit check
// on accept (FIFO occupancy plus reads in flight) keeps the FIFO from
// overflowing, so tok_ready never depends on vec_ready.
module embedding_fetch #(
   parameter int DATA_WIDTH = 8,
   parameter int SEQ_LEN    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   input  logic                    tok_valid,
   output logic                    tok_ready,
   input  logic [9:0]              tok_index,
   output logic                    tbl_read_enable,
   output logic [9:0]              tbl_index,
   input  logic [8*DATA_WIDTH-1:0] tbl_data,
   output logic                    vec_valid,
   input  logic                    vec_ready,
   output logic [8*DATA_WIDTH-1:0] vec_data,
   output logic [7:0]              vec_pos,
   output logic                    vec_last
);

   localparam int         VW       = 8 * DATA_WIDTH;
   localparam logic [8:0] SEQ_N    = 9'(SEQ_LEN);
   localparam logic [7:0] LAST_POS = 8'(SEQ_LEN - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e          state_q, state_d;
   logic [8:0]      issue_q, issue_d;
   logic [8:0]      acc_q, acc_d;
   logic            rd_pend_q;
   logic [7:0]      rd_pos_q;
   logic [VW-1:0]   fifo_data_q [0:2];
   logic [7:0]      fifo_pos_q  [0:2];
   logic [1:0]      wr_ptr_q, rd_ptr_q, cnt_q;
   logic            tok_hs, push, pop;

   function automatic logic [1:0] inc3(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Credit: FIFO entries plus the read in flight must leave a free slot.
   assign tok_ready = (state_q == RUN) && (issue_q < SEQ_N) &&
                      (({1'b0, cnt_q} + {2'b00, rd_pend_q}) < 3'd3);
   assign tok_hs          = tok_valid & tok_ready;
   assign tbl_read_enable = tok_hs;
   assign tbl_index       = tok_index;

   assign push      = rd_pend_q;
   assign vec_valid = (cnt_q != 2'd0);
   assign pop       = vec_valid & vec_ready;
   assign vec_data  = fifo_data_q[rd_ptr_q];
   assign vec_pos   = fifo_pos_q[rd_ptr_q];
   assign vec_last  = vec_valid && (vec_pos == LAST_POS);

   assign busy = (state_q == RUN) || (state_q == DRAIN);
   assign done = (state_q == DONE);

   // Next state and counters; DONE is entered in the cycle after the last pop.
   always_comb begin
      state_d = state_q;
      issue_d = issue_q + 9'(tok_hs);
      acc_d   = acc_q + 9'(pop);
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               issue_d = '0;
               acc_d   = '0;
            end
         end
         RUN:     if (issue_d == SEQ_N) state_d = DRAIN;
         DRAIN:   if (acc_d == SEQ_N)   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state, sequence counters and the one-deep read-in-flight tracker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         issue_q   <= '0;
         acc_q     <= '0;
         rd_pend_q <= 1'b0;
         rd_pos_q  <= '0;
      end else begin
         state_q   <= state_d;
         issue_q   <= issue_d;
         acc_q     <= acc_d;
         rd_pend_q <= tok_hs;
         rd_pos_q  <= issue_q[7:0];
      end
   end

   // Three-entry FIFO of {data, position}; table data is captured only when a read was issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < 3; i++) begin
            fifo_data_q[i] <= '0;
            fifo_pos_q[i]  <= '0;
         end
      end else begin
         if (push) begin
            fifo_data_q[wr_ptr_q] <= tbl_data;
            fifo_pos_q[wr_ptr_q]  <= rd_pos_q;
            wr_ptr_q              <= inc3(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= inc3(rd_ptr_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_embedding_fetch.sv
// tb_embedding_fetch: drives embedding_fetch with SEQ_LEN=4 and checks it
// against a sequence-level reference model. The model tracks tokens issued
// and vectors delivered. It queues expected vectors, and a vector becomes
// visible two cycles after its token is accepted.
module tb_embedding_fetch;

   localparam int DW  = 8;
   localparam int SEQ = 4;
   localparam int VW  = 8 * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          tok_valid = 1'b0;
   logic          vec_ready = 1'b0;
   logic [9:0]    tok_index = '0;
   logic [VW-1:0] tbl_data = '0;
   logic          busy, done, tok_ready, tbl_read_enable, vec_valid, vec_last;
   logic [9:0]    tbl_index;
   logic [VW-1:0] vec_data;
   logic [7:0]    vec_pos;

   embedding_fetch #(.DATA_WIDTH(DW), .SEQ_LEN(SEQ)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_index(tok_index),
      .tbl_read_enable(tbl_read_enable), .tbl_index(tbl_index), .tbl_data(tbl_data),
      .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
      .vec_pos(vec_pos), .vec_last(vec_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model state.
   int          phase;      // 0 idle, 1 active (RUN/DRAIN), 2 done pulse
   int          issued, delivered, cyc;
   logic [63:0] q_data[$];
   int          q_pos[$];
   int          q_rdy[$];
   bit          rd_last;
   logic [9:0]  rd_idx;
   int          rdy_seen, done_seen, done_exp;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Table contents: a fixed scramble of the index.
   function automatic logic [63:0] tbl_f(input logic [9:0] i);
      return ({54'd0, i} * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   task automatic cycle(input bit st, input bit tv, input logic [9:0] idx, input bit vr);
      bit e_tr, e_vv, hs, pp;
      @(negedge clk);
      tbl_data  = rd_last ? tbl_f(rd_idx) : {$urandom, $urandom};
      start     = st;
      tok_valid = tv;
      tok_index = idx;
      vec_ready = vr;
      #1;
      e_tr = (phase == 1) && (issued < SEQ) && ((issued - delivered) < 3);
      e_vv = (q_pos.size() > 0) && (q_rdy[0] <= cyc);
      hs   = tv & e_tr;
      pp   = e_vv & vr;
      chk("tok_ready", 64'(tok_ready), 64'(e_tr));
      chk("busy", 64'(busy), 64'(phase == 1));
      chk("done", 64'(done), 64'(phase == 2));
      chk("vec_valid", 64'(vec_valid), 64'(e_vv));
      chk("rd_en", 64'(tbl_read_enable), 64'(hs));
      if (hs) chk("rd_idx", 64'(tbl_index), 64'(idx));
      if (e_vv) begin
         chk("vec_data", vec_data, q_data[0]);
         chk("vec_pos", 64'(vec_pos), 64'(q_pos[0]));
         chk("vec_last", 64'(vec_last), 64'(q_pos[0] == SEQ - 1));
      end
      if (tok_ready) rdy_seen++;
      if (done) done_seen++;
      // Advance the model across the coming rising edge.
      rd_last = hs;
      rd_idx  = idx;
      if (hs) begin
         q_data.push_back(tbl_f(idx));
         q_pos.push_back(issued);
         q_rdy.push_back(cyc + 2);
         issued++;
      end
      if (pp) begin
         void'(q_data.pop_front());
         void'(q_pos.pop_front());
         void'(q_rdy.pop_front());
         delivered++;
      end
      case (phase)
         0: if (st) begin phase = 1; issued = 0; delivered = 0; end
         1: if (delivered == SEQ) phase = 2;
         default: phase = 0;
      endcase
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      tok_valid = 1'b0;
      start = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_tok_ready", 64'(tok_ready), 64'd0);
      chk("rst_rd_en", 64'(tbl_read_enable), 64'd0);
      chk("rst_vec_valid", 64'(vec_valid), 64'd0);
      chk("rst_vec_data", vec_data, 64'd0);
      chk("rst_vec_pos", 64'(vec_pos), 64'd0);
      chk("rst_vec_last", 64'(vec_last), 64'd0);
      phase = 0; issued = 0; delivered = 0;
      q_data.delete(); q_pos.delete(); q_rdy.delete();
      rd_last = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      phase = 0; issued = 0; delivered = 0; cyc = 0;
      rd_last = 1'b0; rd_idx = '0; rdy_seen = 0; done_seen = 0; done_exp = 0;
      do_reset();

      // Back-to-back indices 5..8 with the sink always ready.
      cycle(1, 0, 10'd0, 1);
      for (int i = 0; i < SEQ; i++) cycle(0, 1, 10'(5 + i), 1);
      for (int i = 0; i < 6; i++) cycle(0, 1, 10'($urandom_range(1023)), 1);
      done_exp++;
      chk("done_b2b", 64'(done_seen), 64'(done_exp));

      // Sink stalled: only three tokens may be accepted, then release.
      cycle(1, 0, 10'd0, 0);
      rdy_seen = 0;
      for (int i = 0; i < 10; i++) cycle(0, 1, 10'($urandom_range(1023)), 0);
      chk("bp_accepts", 64'(rdy_seen), 64'd3);
      for (int i = 0; i < 10; i++) cycle(0, 1, 10'($urandom_range(1023)), 1);
      done_exp++;
      chk("done_bp", 64'(done_seen), 64'(done_exp));

      // Sink toggling every cycle.
      cycle(1, 0, 10'd0, 0);
      for (int i = 0; i < 16; i++) cycle(0, 1, 10'($urandom_range(1023)), i[0]);
      done_exp++;
      chk("done_toggle", 64'(done_seen), 64'(done_exp));

      // Start pulses while running must be ignored.
      cycle(1, 0, 10'd0, 1);
      for (int i = 0; i < 5; i++) cycle(1, 1, 10'($urandom_range(1023)), 1);
      for (int i = 0; i < 6; i++) cycle(0, 1, 10'($urandom_range(1023)), 1);
      done_exp++;
      chk("done_restart", 64'(done_seen), 64'(done_exp));

      // Reset after two tokens, then a fresh sequence from position 0.
      cycle(1, 0, 10'd0, 0);
      for (int i = 0; i < 2; i++) cycle(0, 1, 10'($urandom_range(1023)), 0);
      do_reset();
      cycle(1, 0, 10'd0, 1);
      for (int i = 0; i < 10; i++) cycle(0, 1, 10'($urandom_range(1023)), 1);
      done_exp++;
      chk("done_after_rst", 64'(done_seen), 64'(done_exp));

      // Sparse tokens: valid every third cycle.
      cycle(1, 0, 10'd0, 1);
      for (int i = 0; i < 20; i++) cycle(0, (i % 3) == 0, 10'($urandom_range(1023)), 1);
      done_exp++;
      chk("done_gaps", 64'(done_seen), 64'(done_exp));

      // Random traffic.
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(7) == 0, $urandom_range(1), 10'($urandom_range(1023)),
               $urandom_range(3) != 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
